// File: rtl/prga_pkg.sv
// Shared types for the RC4 pseudo-random generation / decrypt stage.
package arc4_pkg;

  typedef logic [7:0] byte_t;

  localparam int MSG_LEN_MAX = 255;
  localparam int S_SIZE      = 256;

  typedef enum logic [3:0] {
    IDLE, RD_LEN, LATCH_LEN, WR_LEN,
    NEXT_I, RD_I, LATCH_I, RD_J, LATCH_J,
    WR_I, WR_J, RD_PAD, LATCH_PAD, WR_PT
  } prga_state_t;

endpackage

// File: rtl/prga_if.sv
// Start handshake plus S / ciphertext / plaintext RAM ports of the PRGA stage.
interface prga_if;
  import arc4_pkg::*;

  logic  en;
  logic  rdy;
  byte_t s_addr;
  byte_t s_rddata;
  byte_t s_wrdata;
  logic  s_wren;
  byte_t ct_addr;
  byte_t ct_rddata;
  byte_t pt_addr;
  byte_t pt_wrdata;
  logic  pt_wren;

  modport master (
    input  en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  modport slave (
    output en, s_rddata, ct_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
endinterface

// File: rtl/prga.sv
// RC4 keystream generator and decryptor over a shared single-port S RAM.
// Optional PRGA_DROP_EN discards DROP_N keystream bytes before decryption.
module prga
  import arc4_pkg::*;
#(
  parameter int DROP_N = 256
) (
  input  logic    clk,
  input  logic    rst_n,
  prga_if.master  bus
);

  prga_state_t state, state_n;
  byte_t i, j, k, len, si, sj, pad, ctb;
  logic  rdy_q;
  logic  dropping;

`ifdef PRGA_DROP_EN
  logic [8:0] drop_cnt;
  assign dropping = (drop_cnt != 9'd0);
`else
  assign dropping = 1'b0;
  // DROP_N only matters when the drop loop is built in.
  if (DROP_N == 0) begin : g_drop_n_unused
  end
`endif

  assign bus.rdy = rdy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy_q <= 1'b1;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      len   <= '0;
      si    <= '0;
      sj    <= '0;
      pad   <= '0;
      ctb   <= '0;
`ifdef PRGA_DROP_EN
      drop_cnt <= '0;
`endif
    end else begin
      state <= state_n;
      rdy_q <= (state_n == IDLE);
      case (state)
        IDLE: if (bus.en) begin
          i <= '0;
          j <= '0;
          k <= '0;
        end
        LATCH_LEN: len <= bus.ct_rddata;
`ifdef PRGA_DROP_EN
        WR_LEN: drop_cnt <= (bus.ct_rddata == 8'd0 && len == 8'd0) ? 9'd0 : 9'(DROP_N);
`endif
        NEXT_I: begin
          i <= i + 8'd1;
          if (!dropping) k <= k + 8'd1;
        end
        LATCH_I: begin
          si <= bus.s_rddata;
          j  <= j + bus.s_rddata;
        end
        LATCH_J: sj <= bus.s_rddata;
        LATCH_PAD: begin
          pad <= bus.s_rddata;
          ctb <= bus.ct_rddata;
        end
`ifdef PRGA_DROP_EN
        WR_PT: if (dropping) drop_cnt <= drop_cnt - 9'd1;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n       = state;
    bus.s_addr    = '0;
    bus.s_wrdata  = '0;
    bus.s_wren    = 1'b0;
    bus.ct_addr   = '0;
    bus.pt_addr   = '0;
    bus.pt_wrdata = '0;
    bus.pt_wren   = 1'b0;
    case (state)
      IDLE:      if (bus.en) state_n = RD_LEN;
      RD_LEN:    state_n = LATCH_LEN;
      LATCH_LEN: state_n = WR_LEN;
      WR_LEN: begin
        bus.pt_wrdata = len;
        bus.pt_wren   = 1'b1;
        state_n       = (len == 8'd0) ? IDLE : NEXT_I;
      end
      NEXT_I:  state_n = RD_I;
      RD_I: begin
        bus.s_addr = i;
        state_n    = LATCH_I;
      end
      LATCH_I: begin
        bus.s_addr = i;
        state_n    = RD_J;
      end
      RD_J: begin
        bus.s_addr = j;
        state_n    = LATCH_J;
      end
      LATCH_J: begin
        bus.s_addr = j;
        state_n    = WR_I;
      end
      WR_I: begin
        bus.s_addr   = i;
        bus.s_wrdata = sj;
        bus.s_wren   = 1'b1;
        state_n      = WR_J;
      end
      WR_J: begin
        bus.s_addr   = j;
        bus.s_wrdata = si;
        bus.s_wren   = 1'b1;
        state_n      = RD_PAD;
      end
      RD_PAD: begin
        bus.s_addr  = si + sj;
        bus.ct_addr = dropping ? 8'd0 : k;
        state_n     = LATCH_PAD;
      end
      LATCH_PAD: begin
        bus.s_addr  = si + sj;
        bus.ct_addr = dropping ? 8'd0 : k;
        state_n     = WR_PT;
      end
      WR_PT: begin
        // A drop iteration still spends this slot so every keystream byte costs 10 cycles.
        if (dropping) begin
          state_n = NEXT_I;
        end else begin
          bus.pt_addr   = k;
          bus.pt_wrdata = pad ^ ctb;
          bus.pt_wren   = 1'b1;
          state_n       = (k == len) ? IDLE : NEXT_I;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prga.sv
// Directed self-checking bench for prga with behavioural S/ct/pt RAMs.
module tb_prga;
  import arc4_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  prga_if bus();

  prga #(.DROP_N(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  byte_t s_mem [S_SIZE];
  byte_t s_img [S_SIZE];
  byte_t ct_mem[S_SIZE];
  byte_t pt_mem[S_SIZE];
  logic  ld_s = 1'b0;
  logic  clr  = 1'b0;
  int    pt_wr_cnt, s_wr_cnt, both_cnt;

  // RAM models: one-cycle read latency, write on the rising edge.
  always @(posedge clk) begin
    if (ld_s) s_mem <= s_img;
    else if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wrdata;
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.ct_rddata <= ct_mem[bus.ct_addr];
    if (clr) begin
      for (int a = 0; a < S_SIZE; a++) pt_mem[a] <= 8'hAA;
      pt_wr_cnt <= 0;
      s_wr_cnt  <= 0;
      both_cnt  <= 0;
    end else begin
      if (bus.pt_wren) begin
        pt_mem[bus.pt_addr] <= bus.pt_wrdata;
        pt_wr_cnt <= pt_wr_cnt + 1;
      end
      if (bus.s_wren) s_wr_cnt <= s_wr_cnt + 1;
      if (bus.s_wren && bus.pt_wren) both_cnt <= both_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_identity();
    for (int a = 0; a < S_SIZE; a++) s_img[a] = byte_t'(a);
    ld_s = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    ld_s = 1'b0; clr = 1'b0;
  endtask

  task automatic load_ksa_key();
    byte_t key[3];
    byte_t jj, t;
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
    for (int a = 0; a < S_SIZE; a++) s_img[a] = byte_t'(a);
    jj = 8'd0;
    for (int a = 0; a < S_SIZE; a++) begin
      jj = jj + s_img[a] + key[a % 3];
      t = s_img[a]; s_img[a] = s_img[jj]; s_img[jj] = t;
    end
    ld_s = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    ld_s = 1'b0; clr = 1'b0;
  endtask

  task automatic load_ct_plaintext();
    byte_t v[10];
    v = '{8'd9, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int a = 0; a < 10; a++) ct_mem[a] = v[a];
  endtask

  // Starts a run and returns edges from the en-sampling edge until rdy is seen high.
  task automatic run(input bit hold, output int n);
    bus.en = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus.en = 1'b0;
    n = 0;
    while (n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (bus.rdy === 1'b1) break;
    end
    bus.en = 1'b0;
  endtask

  task automatic check_plaintext(input string tag);
    byte_t e[10];
    e = '{8'd9, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    for (int a = 0; a < 10; a++) check($sformatf("%s_pt%0d", tag, a), 32'(pt_mem[a]), 32'(e[a]));
  endtask

  initial begin
    int n;
    bus.en = 1'b0;
    for (int a = 0; a < S_SIZE; a++) ct_mem[a] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdy",       32'(bus.rdy),       32'd1);
    check("reset_s_wren",    32'(bus.s_wren),    32'd0);
    check("reset_pt_wren",   32'(bus.pt_wren),   32'd0);
    check("reset_s_addr",    32'(bus.s_addr),    32'd0);
    check("reset_ct_addr",   32'(bus.ct_addr),   32'd0);
    check("reset_pt_addr",   32'(bus.pt_addr),   32'd0);
    check("reset_s_wrdata",  32'(bus.s_wrdata),  32'd0);
    check("reset_pt_wrdata", 32'(bus.pt_wrdata), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef PRGA_DROP_EN
    // One dropped byte on identity S, then the data byte.
    load_identity();
    ct_mem[0] = 8'd1; ct_mem[1] = 8'h00;
    run(1'b0, n);
    check("drop_latency", 32'(n), 32'd23);
    check("drop_pt0", 32'(pt_mem[0]), 32'd1);
    check("drop_pt1", 32'(pt_mem[1]), 32'h05);
    check("drop_s2",  32'(s_mem[2]),  32'd3);
    check("drop_s3",  32'(s_mem[3]),  32'd2);
    check("drop_ptw", 32'(pt_wr_cnt), 32'd2);
    check("drop_both", 32'(both_cnt), 32'd0);
`else
    // Identity S, one byte.
    load_identity();
    ct_mem[0] = 8'd1; ct_mem[1] = 8'h00;
    run(1'b0, n);
    check("ident_latency", 32'(n), 32'd13);
    check("ident_pt0", 32'(pt_mem[0]), 32'd1);
    check("ident_pt1", 32'(pt_mem[1]), 32'h02);
    check("ident_s1",  32'(s_mem[1]),  32'd1);
    check("ident_ptw", 32'(pt_wr_cnt), 32'd2);
    check("ident_sw",  32'(s_wr_cnt),  32'd2);

    // "Key" / "Plaintext" known-answer.
    load_ksa_key();
    load_ct_plaintext();
    run(1'b0, n);
    check("kat_latency", 32'(n), 32'd93);
    check_plaintext("kat");
    check("kat_ptw",  32'(pt_wr_cnt), 32'd10);
    check("kat_both", 32'(both_cnt),  32'd0);

    // Zero-length message.
    load_identity();
    ct_mem[0] = 8'd0;
    run(1'b0, n);
    check("len0_latency", 32'(n), 32'd3);
    check("len0_pt0", 32'(pt_mem[0]), 32'd0);
    check("len0_pt1", 32'(pt_mem[1]), 32'hAA);
    check("len0_ptw", 32'(pt_wr_cnt), 32'd1);
    check("len0_sw",  32'(s_wr_cnt),  32'd0);

    // en held high for the whole run must not restart it.
    load_ksa_key();
    load_ct_plaintext();
    run(1'b1, n);
    check("hold_latency", 32'(n), 32'd93);
    check_plaintext("hold");
    repeat (20) @(posedge clk);
    #1;
    check("hold_ptw", 32'(pt_wr_cnt), 32'd10);
    check("hold_rdy", 32'(bus.rdy),   32'd1);

    // Asynchronous reset in the middle of a run, then a clean restart.
    load_ksa_key();
    bus.en = 1'b1;
    @(posedge clk); #1;
    bus.en = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    check("mid_busy", 32'(bus.rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdy",     32'(bus.rdy),     32'd1);
    check("mid_rst_s_wren",  32'(bus.s_wren),  32'd0);
    check("mid_rst_pt_wren", 32'(bus.pt_wren), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_ksa_key();
    run(1'b0, n);
    check("rerun_latency", 32'(n), 32'd93);
    check_plaintext("rerun");
    check("rerun_ptw", 32'(pt_wr_cnt), 32'd10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
